// File: rtl/ysyx_23060061_axi_arbiter_pkg.sv
// rtl/ysyx_23060061_axi_arbiter_pkg.sv - shared types and constants for the M0/M1 AXI4-Lite arbiter
package ysyx_23060061_axi_arbiter_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_A,
        WR_B
    } arb_state_e;

endpackage

// File: rtl/ysyx_23060061_arb_grant.sv
// rtl/ysyx_23060061_arb_grant.sv - master select; round-robin when YSYX_23060061_ARB_RR_EN is defined
module ysyx_23060061_arb_grant (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant
);

`ifdef YSYX_23060061_ARB_RR_EN
    logic last_grant;

    // Only a tie consults history; a lone requester always wins.
    always_comb begin
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= grant;
        end
    end
`else
    logic unused_rr;

    assign unused_rr = ^{clk, rst, take};
    assign grant     = req[1];
`endif

endmodule

// File: rtl/ysyx_23060061_axi_arbiter.sv
// rtl/ysyx_23060061_axi_arbiter.sv - two-master to one-slave AXI4-Lite arbiter (optional YSYX_23060061_ARB_RR_EN)
module ysyx_23060061_axi_arbiter
    import ysyx_23060061_axi_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   m0_araddr,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [DW-1:0]   m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    input  logic [AW-1:0]   m0_awaddr,
    input  logic            m0_awvalid,
    output logic            m0_awready,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_wvalid,
    output logic            m0_wready,
    output logic [1:0]      m0_bresp,
    output logic            m0_bvalid,
    input  logic            m0_bready,

    input  logic [AW-1:0]   m1_araddr,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [DW-1:0]   m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    input  logic [AW-1:0]   m1_awaddr,
    input  logic            m1_awvalid,
    output logic            m1_awready,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wvalid,
    output logic            m1_wready,
    output logic [1:0]      m1_bresp,
    output logic            m1_bvalid,
    input  logic            m1_bready,

    output logic [AW-1:0]   s_araddr,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic [AW-1:0]   s_awaddr,
    output logic            s_awvalid,
    input  logic            s_awready,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    output logic            s_wvalid,
    input  logic            s_wready,
    input  logic [1:0]      s_bresp,
    input  logic            s_bvalid,
    output logic            s_bready
);

    arb_state_e state, state_nx;
    logic       grant, grant_sel, take;
    logic       aw_done, w_done;
    logic [1:0] req;

    logic [AW-1:0]   m_araddr [2];
    logic [AW-1:0]   m_awaddr [2];
    logic [DW-1:0]   m_wdata  [2];
    logic [DW/8-1:0] m_wstrb  [2];
    logic [1:0]      m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [1:0]      ar_rdy, r_vld, aw_rdy, w_rdy, b_vld;

    assign m_araddr[0] = m0_araddr;
    assign m_araddr[1] = m1_araddr;
    assign m_awaddr[0] = m0_awaddr;
    assign m_awaddr[1] = m1_awaddr;
    assign m_wdata[0]  = m0_wdata;
    assign m_wdata[1]  = m1_wdata;
    assign m_wstrb[0]  = m0_wstrb;
    assign m_wstrb[1]  = m1_wstrb;
    assign m_arvalid   = {m1_arvalid, m0_arvalid};
    assign m_rready    = {m1_rready,  m0_rready};
    assign m_awvalid   = {m1_awvalid, m0_awvalid};
    assign m_wvalid    = {m1_wvalid,  m0_wvalid};
    assign m_bready    = {m1_bready,  m0_bready};

    assign req  = m_arvalid | m_awvalid;
    assign take = (state == IDLE) && (req != 2'b00);

    ysyx_23060061_arb_grant u_grant (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .take  (take),
        .grant (grant_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                grant <= grant_sel;
            end
            if (state == WR_A) begin
                if (!aw_done && m_awvalid[grant] && s_awready) begin
                    aw_done <= 1'b1;
                end
                if (!w_done && m_wvalid[grant] && s_wready) begin
                    w_done <= 1'b1;
                end
            end
            if (state == WR_B && s_bvalid && m_bready[grant]) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        ar_rdy    = 2'b00;
        r_vld     = 2'b00;
        aw_rdy    = 2'b00;
        w_rdy     = 2'b00;
        b_vld     = 2'b00;
        case (state)
            IDLE: begin
                // A master asserting both AR and AW is taken as a read first.
                if (take) begin
                    state_nx = m_arvalid[grant_sel] ? RD_A : WR_A;
                end
            end
            RD_A: begin
                s_araddr      = m_araddr[grant];
                s_arvalid     = m_arvalid[grant];
                ar_rdy[grant] = s_arready;
                if (m_arvalid[grant] && s_arready) begin
                    state_nx = RD_D;
                end
            end
            RD_D: begin
                r_vld[grant] = s_rvalid;
                s_rready     = m_rready[grant];
                if (s_rvalid && m_rready[grant]) begin
                    state_nx = IDLE;
                end
            end
            WR_A: begin
                if (!aw_done) begin
                    s_awaddr      = m_awaddr[grant];
                    s_awvalid     = m_awvalid[grant];
                    aw_rdy[grant] = s_awready;
                end
                if (!w_done) begin
                    s_wdata      = m_wdata[grant];
                    s_wstrb      = m_wstrb[grant];
                    s_wvalid     = m_wvalid[grant];
                    w_rdy[grant] = s_wready;
                end
                if ((aw_done || (m_awvalid[grant] && s_awready)) &&
                    (w_done  || (m_wvalid[grant]  && s_wready))) begin
                    state_nx = WR_B;
                end
            end
            WR_B: begin
                b_vld[grant] = s_bvalid;
                s_bready     = m_bready[grant];
                if (s_bvalid && m_bready[grant]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m0_arready = ar_rdy[0];
    assign m1_arready = ar_rdy[1];
    assign m0_rvalid  = r_vld[0];
    assign m1_rvalid  = r_vld[1];
    assign m0_awready = aw_rdy[0];
    assign m1_awready = aw_rdy[1];
    assign m0_wready  = w_rdy[0];
    assign m1_wready  = w_rdy[1];
    assign m0_bvalid  = b_vld[0];
    assign m1_bvalid  = b_vld[1];

    // Response payloads reach only the granted master; everyone else sees zeros.
    assign m0_rdata = (state == RD_D && !grant) ? s_rdata : '0;
    assign m0_rresp = (state == RD_D && !grant) ? s_rresp : 2'b00;
    assign m1_rdata = (state == RD_D &&  grant) ? s_rdata : '0;
    assign m1_rresp = (state == RD_D &&  grant) ? s_rresp : 2'b00;
    assign m0_bresp = (state == WR_B && !grant) ? s_bresp : 2'b00;
    assign m1_bresp = (state == WR_B &&  grant) ? s_bresp : 2'b00;

endmodule

// File: tb/tb_ysyx_23060061_axi_arbiter.sv
// tb/tb_ysyx_23060061_axi_arbiter.sv - scoreboard bench for the M0/M1 AXI4-Lite arbiter
module tb_ysyx_23060061_axi_arbiter;
    import ysyx_23060061_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr = '0, m1_araddr = '0, m0_awaddr = '0, m1_awaddr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic m0_arvalid = 0, m0_rready = 0, m0_awvalid = 0, m0_wvalid = 0, m0_bready = 0;
    logic m1_arvalid = 0, m1_rready = 0, m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0;
    logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
    logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;

    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic        s_arready = 1'b1, s_awready = 1'b1, s_wready = 1'b1;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    logic        s_rvalid = 1'b0, s_bvalid = 1'b0;

    ysyx_23060061_axi_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     exp_r0[$], exp_r1[$];
    logic [1:0]  exp_b0[$], exp_b1[$];
    logic [31:0] exp_aw[$];
    logic [35:0] exp_wd[$];
    int          done_order[$];

    int total = 0, bad = 0, cyc = 0;
    int rd_start_cyc[2], rd_ar_cyc[2], rd_r_cyc[2], wr_aw_cyc[2], wr_b_cyc[2];
    int aw_cnt = 0, w_cnt = 0, w_hs_cyc = 0, bready_cyc = 0;
    logic [1:0] slave_rresp = OKAY, slave_bresp = OKAY;
    bit tb_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
    endfunction

    function automatic logic any_out();
        return |{m0_arready, m0_rdata, m0_rresp, m0_rvalid, m0_awready, m0_wready, m0_bresp, m0_bvalid,
                 m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid,
                 s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready};
    endfunction

    function automatic logic get_arready(input int id); return (id == 0) ? m0_arready : m1_arready; endfunction
    function automatic logic get_rvalid(input int id);  return (id == 0) ? m0_rvalid  : m1_rvalid;  endfunction
    function automatic logic get_awready(input int id); return (id == 0) ? m0_awready : m1_awready; endfunction
    function automatic logic get_wready(input int id);  return (id == 0) ? m0_wready  : m1_wready;  endfunction
    function automatic logic get_bvalid(input int id);  return (id == 0) ? m0_bvalid  : m1_bvalid;  endfunction
    function automatic logic [31:0] get_rdata(input int id); return (id == 0) ? m0_rdata : m1_rdata; endfunction
    function automatic logic [1:0] get_rresp(input int id);  return (id == 0) ? m0_rresp : m1_rresp; endfunction
    function automatic logic [1:0] get_bresp(input int id);  return (id == 0) ? m0_bresp : m1_bresp; endfunction

    task automatic set_ar(input int id, input logic v, input logic [31:0] a);
        if (id == 0) begin m0_arvalid = v; m0_araddr = a; end
        else begin m1_arvalid = v; m1_araddr = a; end
    endtask

    task automatic set_aw(input int id, input logic v, input logic [31:0] a);
        if (id == 0) begin m0_awvalid = v; m0_awaddr = a; end
        else begin m1_awvalid = v; m1_awaddr = a; end
    endtask

    task automatic set_w(input int id, input logic v, input logic [31:0] d, input logic [3:0] s);
        if (id == 0) begin m0_wvalid = v; m0_wdata = d; m0_wstrb = s; end
        else begin m1_wvalid = v; m1_wdata = d; m1_wstrb = s; end
    endtask

    task automatic set_rready(input int id, input logic v);
        if (id == 0) m0_rready = v; else m1_rready = v;
    endtask

    task automatic set_bready(input int id, input logic v);
        if (id == 0) m0_bready = v; else m1_bready = v;
    endtask

    // Zero-wait read slave: one beat after each AR handshake, abandoned by reset.
    initial begin : rd_slave
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rst && s_arvalid && s_arready) begin
                a = s_araddr;
                @(posedge clk); #1;
                s_rdata  = slave_rdata(a);
                s_rresp  = slave_rresp;
                s_rvalid = 1'b1;
                @(negedge clk);
                while (rst && !s_rready) @(negedge clk);
                @(posedge clk); #1;
                s_rvalid = 1'b0;
                s_rdata  = '0;
                s_rresp  = '0;
            end
        end
    end

    // Write slave: takes AW and W independently, answers once both have arrived.
    initial begin : wr_slave
        bit got_aw, got_w;
        logic [31:0] ea;
        logic [35:0] ew;
        got_aw = 0;
        got_w  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                got_aw = 0;
                got_w  = 0;
                continue;
            end
            if (s_awvalid && s_awready) begin
                got_aw = 1;
                aw_cnt++;
                total++;
                if (exp_aw.size() == 0) begin
                    bad++; $display("FAIL slave_aw got addr=%h required none", s_awaddr);
                end else begin
                    ea = exp_aw.pop_front();
                    if (s_awaddr !== ea) begin bad++; $display("FAIL slave_aw got addr=%h required %h", s_awaddr, ea); end
                end
            end
            if (s_wvalid && s_wready) begin
                got_w = 1;
                w_cnt++;
                w_hs_cyc = cyc;
                total++;
                if (exp_wd.size() == 0) begin
                    bad++; $display("FAIL slave_w got %h/%h required none", s_wstrb, s_wdata);
                end else begin
                    ew = exp_wd.pop_front();
                    if ({s_wstrb, s_wdata} !== ew) begin
                        bad++; $display("FAIL slave_w got %h required %h", {s_wstrb, s_wdata}, ew);
                    end
                end
            end
            if (got_aw && got_w) begin
                @(posedge clk); #1;
                s_bvalid = 1'b1;
                s_bresp  = slave_bresp;
                forever begin
                    @(negedge clk);
                    if (!rst || s_bready) break;
                end
                if (s_bready) bready_cyc = cyc;
                @(posedge clk); #1;
                s_bvalid = 1'b0;
                s_bresp  = '0;
                got_aw   = 0;
                got_w    = 0;
            end
        end
    end

    task automatic do_read(input int id, input logic [31:0] addr, input int r_hold);
        rd_exp_t e;
        bit ar_pend, fin, seen, rr, ar_hs, r_hs, rv;
        int n, held;
        e.data = slave_rdata(addr);
        e.resp = slave_rresp;
        if (id == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
        set_ar(id, 1'b1, addr);
        rr = (r_hold == 0);
        set_rready(id, rr);
        ar_pend = 1; fin = 0; seen = 0; n = 0; held = 0;
        while (!fin && n < 200) begin
            @(negedge clk);
            if (n == 0) rd_start_cyc[id] = cyc;
            rv    = get_rvalid(id);
            ar_hs = ar_pend && get_arready(id);
            r_hs  = rv && rr;
            if (ar_hs) rd_ar_cyc[id] = cyc;
            if (!rr && (seen || rv)) begin
                seen = 1;
                held++;
                total++;
                if (rv !== 1'b1 || s_rready !== 1'b0) begin
                    bad++; $display("FAIL rd_hold m%0d got rvalid=%b s_rready=%b required 1/0", id, rv, s_rready);
                end
            end
            if (r_hs) begin
                rd_r_cyc[id] = cyc;
                if (id == 0) e = exp_r0.pop_front(); else e = exp_r1.pop_front();
                total++;
                if (get_rdata(id) !== e.data || get_rresp(id) !== e.resp) begin
                    bad++;
                    $display("FAIL rd_data m%0d got %h/%b required %h/%b", id, get_rdata(id), get_rresp(id), e.data, e.resp);
                end
            end
            @(posedge clk); #1;
            if (ar_hs) begin ar_pend = 0; set_ar(id, 1'b0, '0); end
            if (r_hs) begin fin = 1; set_rready(id, 1'b0); done_order.push_back(id); tb_last = id[0]; end
            if (!rr && held >= r_hold) begin rr = 1; set_rready(id, 1'b1); end
            n++;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL rd_timeout m%0d got no R handshake required one within 200 cycles", id);
            set_ar(id, 1'b0, '0);
            set_rready(id, 1'b0);
        end
    endtask

    task automatic do_write(input int id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        bit aw_pend, w_pend, w_on, fin, aw_hs, w_hs, b_hs;
        logic [1:0] eb;
        int n;
        exp_aw.push_back(addr);
        exp_wd.push_back({strb, data});
        if (id == 0) exp_b0.push_back(slave_bresp); else exp_b1.push_back(slave_bresp);
        set_aw(id, 1'b1, addr);
        set_bready(id, 1'b1);
        w_on = (lead == 0);
        if (w_on) set_w(id, 1'b1, data, strb);
        aw_pend = 1; w_pend = 1; fin = 0; n = 0;
        while (!fin && n < 200) begin
            @(negedge clk);
            aw_hs = aw_pend && get_awready(id);
            w_hs  = w_on && w_pend && get_wready(id);
            b_hs  = get_bvalid(id);
            if (aw_hs) wr_aw_cyc[id] = cyc;
            if (b_hs) begin
                wr_b_cyc[id] = cyc;
                if (id == 0) eb = exp_b0.pop_front(); else eb = exp_b1.pop_front();
                total++;
                if (get_bresp(id) !== eb) begin
                    bad++; $display("FAIL wr_bresp m%0d got %b required %b", id, get_bresp(id), eb);
                end
            end
            @(posedge clk); #1;
            if (aw_hs) begin aw_pend = 0; set_aw(id, 1'b0, '0); end
            if (w_hs) begin w_pend = 0; set_w(id, 1'b0, '0, '0); end
            if (b_hs) begin fin = 1; set_bready(id, 1'b0); done_order.push_back(id); tb_last = id[0]; end
            n++;
            if (!w_on && n >= lead) begin w_on = 1; set_w(id, 1'b1, data, strb); end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL wr_timeout m%0d got no B handshake required one within 200 cycles", id);
            set_aw(id, 1'b0, '0);
            set_w(id, 1'b0, '0, '0);
            set_bready(id, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_outputs got nonzero=%b required 0", any_out()); end
        @(posedge clk); #1;
        rst = 1'b1;
        tb_last = 1'b1;
    endtask

    task automatic test_read_m0();
        fork
            do_read(0, 32'h8000_0000, 0);
            begin
                bit seen1 = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (m1_arready | m1_awready | m1_wready | m1_rvalid | m1_bvalid) seen1 = 1;
                end
                total++;
                if (seen1 !== 1'b0) begin bad++; $display("FAIL m1_idle got ready/valid=%b required 0", seen1); end
            end
        join
        total++;
        if (rd_ar_cyc[0] - rd_start_cyc[0] !== 1) begin
            bad++; $display("FAIL ar_latency got %0d required 1", rd_ar_cyc[0] - rd_start_cyc[0]);
        end
        total++;
        if (rd_r_cyc[0] - rd_start_cyc[0] !== 2) begin
            bad++; $display("FAIL rd_latency got %0d required 2", rd_r_cyc[0] - rd_start_cyc[0]);
        end
    endtask

    task automatic test_contention();
        int efirst;
`ifdef YSYX_23060061_ARB_RR_EN
        efirst = tb_last ? 0 : 1;
`else
        efirst = 1;
`endif
        done_order.delete();
        fork
            do_read(0, 32'h8000_0010, 0);
            do_write(1, 32'hA000_03F8, 32'h0000_0041, 4'h1, 0);
        join
        total++;
        if (done_order.size() != 2) begin
            bad++; $display("FAIL cont_count got %0d required 2", done_order.size());
        end else begin
            if (done_order[0] !== efirst || done_order[1] !== 1 - efirst) begin
                bad++; $display("FAIL cont_order got %0d,%0d required %0d,%0d", done_order[0], done_order[1], efirst, 1 - efirst);
            end
            total++;
            if (efirst == 1) begin
                if (rd_ar_cyc[0] !== wr_b_cyc[1] + 2) begin
                    bad++; $display("FAIL cont_gap got %0d required %0d", rd_ar_cyc[0], wr_b_cyc[1] + 2);
                end
            end else begin
                if (wr_aw_cyc[1] !== rd_r_cyc[0] + 2) begin
                    bad++; $display("FAIL cont_gap got %0d required %0d", wr_aw_cyc[1], rd_r_cyc[0] + 2);
                end
            end
        end
    endtask

    task automatic test_aw_lead();
        aw_cnt = 0;
        w_cnt  = 0;
        slave_bresp = DECERR;
        do_write(1, 32'hA000_0100, 32'h1234_5678, 4'hF, 3);
        slave_bresp = OKAY;
        total++;
        if (aw_cnt !== 1) begin bad++; $display("FAIL lead_aw_count got %0d required 1", aw_cnt); end
        total++;
        if (w_cnt !== 1) begin bad++; $display("FAIL lead_w_count got %0d required 1", w_cnt); end
        total++;
        if (bready_cyc !== w_hs_cyc + 1) begin
            bad++; $display("FAIL lead_wr_b got cycle %0d required %0d", bready_cyc, w_hs_cyc + 1);
        end
    endtask

    task automatic test_error_resp();
        slave_rresp = SLVERR;
        do_read(0, 32'h8000_0040, 4);
        slave_rresp = OKAY;
    endtask

    task automatic test_mid_reset();
        int n;
        set_ar(0, 1'b1, 32'h8000_0020);
        m0_rready = 1'b0;
        n = 0;
        while (!m0_arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        set_ar(0, 1'b0, '0);
        n = 0;
        while (!m0_rvalid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL mid_reset_rd_d got rvalid=%b required 1", m0_rvalid); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (any_out() !== 1'b0) begin bad++; $display("FAIL mid_reset_outputs got nonzero=%b required 0", any_out()); end
        @(posedge clk); #1;
        rst = 1'b1;
        tb_last = 1'b1;
        do_read(0, 32'h8000_0080, 0);
    endtask

`ifdef YSYX_23060061_ARB_RR_EN
    task automatic test_round_robin();
        int exp_rr [3] = '{0, 1, 0};
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        tb_last = 1'b1;
        done_order.delete();
        repeat (2) begin
            fork
                do_read(0, 32'h8000_0100, 0);
                do_write(1, 32'hA000_03F8, 32'h0000_0041, 4'h1, 0);
            join
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done_order.size() <= i) begin
                bad++; $display("FAIL rr_grant%0d got none required m%0d", i, exp_rr[i]);
            end else if (done_order[i] !== exp_rr[i]) begin
                bad++; $display("FAIL rr_grant%0d got m%0d required m%0d", i, done_order[i], exp_rr[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_m0();
        test_contention();
        test_aw_lead();
        test_error_resp();
        test_mid_reset();
`ifdef YSYX_23060061_ARB_RR_EN
        test_round_robin();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060061_axi_arbiter.md
Name: ysyx_23060061_axi_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter between the core's instruction-fetch unit (M0) and load/store unit (M1).
- Its single master port drives the CPU-side port of the XBar. It replaces ad-hoc sharing of that port.
- One transaction is in flight at a time. The grant is held from address acceptance until the final response handshake.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- m{0,1}_araddr/arvalid/arready  in/in/out  AW/1/1  read address channel per master.
- m{0,1}_rdata/rresp/rvalid/rready  out/out/out/in  DW/2/1/1  read data channel per master.
- m{0,1}_awaddr/awvalid/awready  in/in/out  AW/1/1  write address channel per master.
- m{0,1}_wdata/wstrb/wvalid/wready  in/in/in/out  DW/DW/8/1/1  write data channel per master.
- m{0,1}_bresp/bvalid/bready  out/out/in  2/1/1  write response channel per master.
- s_araddr/arvalid/arready  out/out/in  AW/1/1  read address channel to XBar.
- s_rdata/rresp/rvalid/rready  in/in/in/out  DW/2/1/1  read data channel from XBar.
- s_awaddr/awvalid/awready  out/out/in  AW/1/1  write address channel to XBar.
- s_wdata/wstrb/wvalid/wready  out/out/out/in  DW/DW/8/1/1  write data channel to XBar.
- s_bresp/bvalid/bready  in/in/out  2/1/1  write response channel from XBar.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, grant=0.
  - Every valid/ready output is 0. All data outputs are 0.
  - This applies mid-transaction too: the slave transaction is abandoned and no response is forwarded.
- Request from master i: req_i = arvalid_i | awvalid_i.
  - If a master asserts both, it is serviced as a read first.
- State IDLE:
  - No request: stay in IDLE.
  - Otherwise register grant (fixed priority: M1 over M0) and the granted master's direction.
  - Go to RD_A or WR_A. The arbitration decision costs exactly 1 cycle.
  - No ready is asserted to any master while in IDLE.
- State RD_A:
  - Connect the granted master's AR to s_AR combinationally.
  - On s_arvalid & s_arready, go to RD_D.
- State RD_D:
  - Route s_R to the granted master; the other master sees rvalid=0.
  - s_rready = granted master's rready.
  - On the handshake, go to IDLE.
- State WR_A:
  - Forward AW and W independently; aw_done and w_done flags latch each handshake.
  - A channel already done has its s_valid forced to 0.
  - When both are done (same cycle or staggered), go to WR_B.
- State WR_B:
  - Route s_B to the granted master.
  - On the handshake, go to IDLE and clear both flags.
- Non-granted master: all its ready and valid outputs are 0. Its pending valid must stay asserted, per AXI rule.
- Throughput and latency:
  - Back-to-back transactions have one IDLE cycle between them.
  - Minimum read latency is 3 cycles with a zero-wait slave.
- Error responses: rresp and bresp pass through unmodified.
- Slave stall: an arbitrarily long stall holds the state; there is no timeout.
- Grant and direction are stable for the whole transaction, even if the requester drops valid illegally.

Optional Feature:
- Macro YSYX_23060061_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. A 1-bit last_grant register is reset to 1.
  - On simultaneous requests in IDLE, grant the master that is not last_grant.
  - last_grant updates on each grant.
- Undefined: fixed priority, M1 over M0. No last_grant register exists.

Decomposition:
- Shared package:
  - State enum: IDLE, RD_A, RD_D, WR_A, WR_B.
  - Response code constants: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - AW and DW defaults.
- Sub-module ysyx_23060061_arb_grant:
  - Combinational priority/round-robin select plus the last_grant register.
  - Isolates the optional feature from the channel mux and FSM.

Test Plan:
- M0 read at 0x8000_0000 alone, slave returns 0xDEAD_BEEF with a zero-wait slave:
  - s_arvalid is asserted the cycle after IDLE.
  - m0_rdata=0xDEAD_BEEF and rresp=0.
  - M1 sees no ready.
- M0 read and M1 write to 0xA000_03F8 (wdata 0x41, wstrb 0x1) in the same cycle, fixed priority:
  - M1 write completes first.
  - M0 read is granted 1 cycle after the B handshake.
  - With YSYX_23060061_ARB_RR_EN, repeat the contention: grants alternate M0, M1, M0.
- M1 write with awvalid 3 cycles before wvalid:
  - Single s_awvalid handshake and single s_wvalid handshake; no duplicate AW.
  - WR_B is entered after the W handshake.
- Slave returns rresp=2'b10 and holds rvalid while the master deasserts rready for 4 cycles:
  - m_rresp=2'b10.
  - State stays RD_D until rready=1.
- rst=0 asserted during RD_D:
  - Next cycle: all valid/ready outputs are 0 and state is IDLE.
  - A fresh M0 read after release completes normally.
